// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU opcodes, arbiter FSM states
// and the round-robin index helper.
package alu_pkg;

  localparam logic [2:0] OP_ADDU = 3'd0;
  localparam logic [2:0] OP_ADDS = 3'd1;
  localparam logic [2:0] OP_SUBU = 3'd2;
  localparam logic [2:0] OP_SUBS = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_SHR1 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Requester index visited 'off' steps after 'base', wrapping modulo n.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: packed per-requester issue slices
// plus the shared tagged response.
interface alu_arbiter_if #(
  parameter int NUMBITS = 16,
  parameter int NREQ    = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*NUMBITS-1:0] req_a;
  logic [NREQ*NUMBITS-1:0] req_b;
  logic [NREQ*3-1:0]       req_op;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [NUMBITS-1:0]      rsp_result;
  logic                    rsp_carryout;
  logic                    rsp_overflow;
  logic                    rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
// The pointer register itself lives in alu_arbiter.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] idx_s;
  logic           found_s;

  // Walk ptr+1 .. ptr+NREQ and keep the first asserted request.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx_s = IDW'(rr_index(int'(ptr), off, NREQ));
      if (!found_s && req[idx_s]) begin
        found_s    = 1'b1;
        gnt[idx_s] = 1'b1;
        gnt_id     = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/myalu.sv
// Registered ALU shared by the arbiter clients; zero flag is only meaningful
// for OP_ADDU.
module myalu
  import alu_pkg::*;
#(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic [2:0]         opcode,
  output logic [NUMBITS-1:0] result,
  output logic               carryout,
  output logic               overflow,
  output logic               zero
);

  logic [NUMBITS:0]   sum_s, diff_s;
  logic [NUMBITS-1:0] result_d, result_q;
  logic               carryout_d, carryout_q;
  logic               overflow_d, overflow_q;
  logic               zero_d, zero_q;

  assign sum_s  = {1'b0, A} + {1'b0, B};
  assign diff_s = {1'b0, A} - {1'b0, B};

  // Operation decode; carryout on subtract is the borrow out.
  always_comb begin
    result_d   = '0;
    carryout_d = 1'b0;
    overflow_d = 1'b0;
    case (opcode)
      OP_ADDU: begin
        result_d   = sum_s[NUMBITS-1:0];
        carryout_d = sum_s[NUMBITS];
      end
      OP_ADDS: begin
        result_d   = sum_s[NUMBITS-1:0];
        overflow_d = (A[NUMBITS-1] == B[NUMBITS-1]) && (sum_s[NUMBITS-1] != A[NUMBITS-1]);
      end
      OP_SUBU: begin
        result_d   = diff_s[NUMBITS-1:0];
        carryout_d = diff_s[NUMBITS];
      end
      OP_SUBS: begin
        result_d   = diff_s[NUMBITS-1:0];
        overflow_d = (A[NUMBITS-1] != B[NUMBITS-1]) && (diff_s[NUMBITS-1] != A[NUMBITS-1]);
      end
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_XOR:  result_d = A ^ B;
      OP_SHR1: begin
        result_d   = A >> 1;
        carryout_d = A[0];
      end
      default: result_d = '0;
    endcase
    zero_d = (opcode == OP_ADDU) && (result_d == '0);
  end

  // Result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      result_q   <= result_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign result   = result_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NREQ requesters.
// Build option ALU_ARB_ZERO_FIX_EN: rsp_zero reflects result==0 for every opcode.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int NREQ    = 4
) (
  input  logic               clk,
  input  logic               reset,
  alu_arbiter_if.slave       bus,
  output logic               alu_reset,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero
);

  localparam int IDW = $clog2(NREQ);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [NUMBITS-1:0] alu_a_q, alu_a_d;
  logic [NUMBITS-1:0] alu_b_q, alu_b_d;
  logic [2:0]         alu_opcode_q, alu_opcode_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [NUMBITS-1:0] rsp_result_q, rsp_result_d;
  logic               rsp_carryout_q, rsp_carryout_d;
  logic               rsp_overflow_q, rsp_overflow_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               zero_s;

  logic [NREQ-1:0]    arb_req_s;
  logic [NREQ-1:0]    gnt_s;
  logic [IDW-1:0]     gnt_id_s;
  logic [NUMBITS-1:0] req_a_s  [NREQ];
  logic [NUMBITS-1:0] req_b_s  [NREQ];
  logic [2:0]         req_op_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_a_s[g]  = bus.req_a[g*NUMBITS +: NUMBITS];
    assign req_b_s[g]  = bus.req_b[g*NUMBITS +: NUMBITS];
    assign req_op_s[g] = bus.req_op[g*3 +: 3];
  end

  // Only offer requests to the picker when a grant can actually be taken.
  assign arb_req_s = (state_q == ST_IDLE && !reset) ? bus.req_valid : '0;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req    (arb_req_s),
    .ptr    (ptr_q),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

`ifdef ALU_ARB_ZERO_FIX_EN
  assign zero_s = (alu_result == '0);
`else
  assign zero_s = alu_zero;
`endif

  // Next-state and datapath capture.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_id_d       = gnt_id_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_opcode_d   = alu_opcode_q;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_carryout_d = rsp_carryout_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_zero_d     = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt_s) begin
          state_d      = ST_EXEC;
          ptr_d        = gnt_id_s;
          gnt_id_d     = gnt_id_s;
          alu_a_d      = req_a_s[gnt_id_s];
          alu_b_d      = req_b_s[gnt_id_s];
          alu_opcode_d = req_op_s[gnt_id_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        // ALU registered its result at the edge that ended EXEC.
        state_d        = ST_IDLE;
        rsp_valid_d    = 1'b1;
        rsp_id_d       = gnt_id_q;
        rsp_result_d   = alu_result;
        rsp_carryout_d = alu_carryout;
        rsp_overflow_d = alu_overflow;
        rsp_zero_d     = zero_s;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= IDW'(NREQ - 1);
      gnt_id_q       <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_opcode_q   <= 3'd0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_carryout_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_id_q       <= gnt_id_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_opcode_q   <= alu_opcode_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carryout_q <= rsp_carryout_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_zero_q     <= rsp_zero_d;
    end
  end

  assign bus.req_ready    = gnt_s;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carryout = rsp_carryout_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign alu_reset        = reset;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_opcode       = alu_opcode_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a real myalu, NREQ=4.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NB = 16;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUMBITS(NB), .NREQ(NR)) bus();

  logic          alu_reset;
  logic [NB-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_opcode;
  logic          alu_carryout, alu_overflow, alu_zero;

  logic [NR-1:0] tv;
  logic [NB-1:0] ta [NR];
  logic [NB-1:0] tbv[NR];
  logic [2:0]    top[NR];

  assign bus.req_valid = tv;
  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign bus.req_a[g*NB +: NB] = ta[g];
    assign bus.req_b[g*NB +: NB] = tbv[g];
    assign bus.req_op[g*3 +: 3]  = top[g];
  end

  alu_arbiter #(.NUMBITS(NB), .NREQ(NR)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_reset(alu_reset), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  myalu #(.NUMBITS(NB)) u_alu (
    .clk(clk), .reset(alu_reset), .A(alu_a), .B(alu_b), .opcode(alu_opcode),
    .result(alu_result), .carryout(alu_carryout), .overflow(alu_overflow), .zero(alu_zero)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic [2:0] op,
                         input logic [NB-1:0] a, input logic [NB-1:0] b);
    tv[i]  = 1'b1;
    top[i] = op;
    ta[i]  = a;
    tbv[i] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  // Waits (bounded) for rsp_valid; cyc counts edges taken.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (cyc < 8) begin
      tick();
      cyc++;
      if (bus.rsp_valid === 1'b1) break;
    end
    total++;
    if (bus.rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", bus.rsp_valid, cyc);
    end
  endtask

  task automatic test_reset();
    tv = 4'hF;
    reset = 1'b1;
    repeat (2) tick();
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data: id=%0d result=%h want 0/0000", bus.rsp_id, bus.rsp_result); end
    total++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000 || alu_opcode !== 3'd0) begin bad++; $display("FAIL reset_alu_in: a=%h b=%h op=%0d want 0", alu_a, alu_b, alu_opcode); end
    total++; if (alu_reset !== 1'b1) begin bad++; $display("FAIL reset_alu_reset: got %b want 1", alu_reset); end
    tv = 4'h0;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_basic();
    int cyc;
    set_req(2'd0, OP_ADDU, 16'hFFFF, 16'h0001);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL basic_ready: got %b want 0001", bus.req_ready); end
    tick();
    tv = 4'h0;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL basic_ready_exec: got %b want 0000", bus.req_ready); end
    total++; if (alu_a !== 16'hFFFF || alu_b !== 16'h0001 || alu_opcode !== OP_ADDU) begin bad++; $display("FAIL basic_alu_in: a=%h b=%h op=%0d want FFFF/0001/0", alu_a, alu_b, alu_opcode); end
    wait_rsp(cyc);
    total++; if (cyc != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2 edges after accept", cyc); end
    total++; if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 16'h0000) begin bad++; $display("FAIL basic_rsp: id=%0d result=%h want 0/0000", bus.rsp_id, bus.rsp_result); end
    total++; if (bus.rsp_carryout !== 1'b1 || bus.rsp_zero !== 1'b1 || bus.rsp_overflow !== 1'b0) begin bad++; $display("FAIL basic_flags: c=%b z=%b v=%b want 1/1/0", bus.rsp_carryout, bus.rsp_zero, bus.rsp_overflow); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 16'h0000 || bus.rsp_carryout !== 1'b1) begin bad++; $display("FAIL basic_pulse_hold: valid=%b result=%h c=%b want 0/0000/1", bus.rsp_valid, bus.rsp_result, bus.rsp_carryout); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int exp_id;
    logic [NB-1:0] exp_r;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(2'(i), OP_ADDU, 16'(16'h1111 * (i + 1)), 16'h0001);
    #1;
    for (int k = 0; k < 12; k++) begin
      exp_id = k % NR;
      exp_r  = 16'(16'h1111 * (exp_id + 1) + 1);
      total++; if (bus.req_ready !== (4'b0001 << exp_id)) begin bad++; $display("FAIL rr_grant[%0d]: got %b want id %0d", k, bus.req_ready, exp_id); end
      tick();
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rr_busy[%0d]: got %b want 0000", k, bus.req_ready); end
      wait_rsp(cyc);
      total++; if (cyc != 2) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want 2", k, cyc); end
      total++; if (bus.rsp_id !== 2'(exp_id)) begin bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, bus.rsp_id, exp_id); end
      total++; if (bus.rsp_result !== exp_r) begin bad++; $display("FAIL rr_result[%0d]: got %h want %h", k, bus.rsp_result, exp_r); end
    end
    tv = 4'h0;
    #1;
  endtask

  task automatic test_signed();
    int cyc;
    set_req(2'd2, OP_ADDS, 16'h7FFF, 16'h0001);
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL adds_ready: got %b want 0100", bus.req_ready); end
    tick();
    tv = 4'h0;
    wait_rsp(cyc);
    total++; if (bus.rsp_id !== 2'd2 || bus.rsp_result !== 16'h8000) begin bad++; $display("FAIL adds_rsp: id=%0d result=%h want 2/8000", bus.rsp_id, bus.rsp_result); end
    total++; if (bus.rsp_overflow !== 1'b1 || bus.rsp_carryout !== 1'b0) begin bad++; $display("FAIL adds_flags: v=%b c=%b want 1/0", bus.rsp_overflow, bus.rsp_carryout); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int cyc;
    bit seen = 1'b0;
    set_req(2'd1, OP_SUBU, 16'h0003, 16'h0005);
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL midrst_ready: got %b want 0010", bus.req_ready); end
    tick();
    tv = 4'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    total++; if (seen) begin bad++; $display("FAIL midrst_no_rsp: rsp_valid seen=1 want 0"); end
    total++; if (bus.rsp_result !== 16'h0000 || bus.rsp_id !== 2'd0 || bus.rsp_overflow !== 1'b0) begin bad++; $display("FAIL midrst_regs: result=%h id=%0d v=%b want 0", bus.rsp_result, bus.rsp_id, bus.rsp_overflow); end
    set_req(2'd0, OP_ADDU, 16'h0010, 16'h0020);
    set_req(2'd1, OP_SUBU, 16'h0003, 16'h0005);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_ptr: got %b want 0001", bus.req_ready); end
    tick();
    tv = 4'h0;
    wait_rsp(cyc);
    total++; if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 16'h0030) begin bad++; $display("FAIL midrst_next: id=%0d result=%h want 0/0030", bus.rsp_id, bus.rsp_result); end
    tick();
  endtask

  task automatic test_zero_flag();
    int cyc;
    logic exp_z;
`ifdef ALU_ARB_ZERO_FIX_EN
    exp_z = 1'b1;
`else
    exp_z = 1'b0;
`endif
    set_req(2'd3, OP_AND, 16'h00F0, 16'h0F00);
    #1;
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL and_ready: got %b want 1000", bus.req_ready); end
    tick();
    tv = 4'h0;
    wait_rsp(cyc);
    total++; if (bus.rsp_id !== 2'd3 || bus.rsp_result !== 16'h0000) begin bad++; $display("FAIL and_rsp: id=%0d result=%h want 3/0000", bus.rsp_id, bus.rsp_result); end
    total++; if (bus.rsp_zero !== exp_z) begin bad++; $display("FAIL and_zero: got %b want %b", bus.rsp_zero, exp_z); end
    tick();
  endtask

  task automatic test_drop();
    int cyc;
    bit bad_seen = 1'b0;
    set_req(2'd0, OP_XOR, 16'h00FF, 16'h0F0F);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL drop_ready0: got %b want 0001", bus.req_ready); end
    tick();
    tv[0] = 1'b0;
    set_req(2'd1, OP_ADDU, 16'h1234, 16'h0001);
    #1;
    if (bus.req_ready[1] !== 1'b0) bad_seen = 1'b1;
    tick();
    if (bus.req_ready[1] !== 1'b0) bad_seen = 1'b1;
    tv[1] = 1'b0;
    wait_rsp(cyc);
    total++; if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 16'h0FF0) begin bad++; $display("FAIL drop_rsp0: id=%0d result=%h want 0/0FF0", bus.rsp_id, bus.rsp_result); end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.req_ready[1] !== 1'b0) bad_seen = 1'b1;
    end
    total++; if (bad_seen) begin bad++; $display("FAIL drop_req1: ready1 or rsp seen=1 want 0"); end
  endtask

  initial begin
    reset = 1'b1;
    tv = '0;
    for (int i = 0; i < NR; i++) begin
      ta[i]  = '0;
      tbv[i] = '0;
      top[i] = 3'd0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_signed();
    test_reset_midflight();
    test_zero_flag();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
